// File: rtl/dmem_if.sv
// dmem_if: request/response bus of the pipelined data memory.
// The master issues requests and collects read responses; the slave is the memory.
interface dmem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W/8-1:0] req_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_pipe.sv
// dmem_pipe: word memory with byte-enable writes, RD_LAT-stage read pipeline and a post-reset clear sequencer.
// Defining DMEM_ALIGN_CHECK_EN turns misaligned accesses into error responses.
module dmem_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [RD_LAT-1:0] vld_q, vld_d, err_q, err_d;
    logic [DATA_W-1:0] dat_q [RD_LAT];
    logic [DATA_W-1:0] dat_d [RD_LAT];
    logic              clearing, acc, mis, wr_en;
    logic [IDX_W-1:0]  idx, wr_idx;
    logic [DATA_W-1:0] rd_word, wr_word;

    assign clearing      = state_q == CLEAR;
    assign bus.req_ready = !clearing;
    assign bus.busy      = clearing;
    assign acc           = bus.req_valid & !clearing;
    assign idx           = bus.req_addr[OFF +: IDX_W];
    assign rd_word       = mem_q[idx];
`ifdef DMEM_ALIGN_CHECK_EN
    assign mis = (bus.req_addr & ADDR_W'((1 << OFF) - 1)) != '0;
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_d = (clearing && cnt_q == IDX_W'(DEPTH - 1)) ? RUN : state_q;
        cnt_d   = clearing ? cnt_q + 1'b1 : cnt_q;
        wr_en   = clearing | (acc & bus.req_we & !mis);
        wr_idx  = clearing ? cnt_q : idx;
        wr_word = rd_word;
        for (int i = 0; i < NB; i++)
            if (bus.req_be[i]) wr_word[8*i +: 8] = bus.req_wdata[8*i +: 8];
        if (clearing) wr_word = '0;
        // Data and error stages only advance with a valid, so the output holds between responses.
        vld_d[0] = acc & (!bus.req_we | mis);
        err_d[0] = vld_d[0] ? mis : err_q[0];
        dat_d[0] = vld_d[0] ? (mis ? '0 : rd_word) : dat_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = vld_q[i-1] ? err_q[i-1] : err_q[i];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            vld_q   <= '0;
            err_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= dat_d[i];
        end
    end

    // The array itself is not reset; the clear sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_word;
    end

    assign bus.rsp_valid = vld_q[RD_LAT-1];
    assign bus.rsp_rdata = dat_q[RD_LAT-1];
    assign bus.rsp_err   = err_q[RD_LAT-1];
endmodule

// File: doc/dmem_pipe.md
# dmem_pipe

Parametrised, pipelined data memory for the single-cycle/pipelined datapaths. It replaces the fixed 1024×32 asynchronous-read memory with a configurable word array behind a valid/ready request port. Reads have a fixed, configurable latency; writes use per-byte enables. After every reset, a hardware clear sequencer zeroes the whole array. The block sits between the datapath's memory stage and the load/store writeback logic.

## Interface
- DATA_W, 32: word width in bits; a multiple of 8 and a power of two.
- DEPTH, 1024: number of words; a power of two, at least 2.
- ADDR_W, 32: byte-address width.
- RD_LAT, 1: read latency in cycles, legal range 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte-lane write enables; lane i covers bits [8i+7:8i].
- rsp_valid  out  1  read data valid, single-cycle pulse per response.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  error qualifier for rsp_valid.
- busy  out  1  clear sequence in progress.

## Operation
- Derived values:
  - OFF = log2(DATA_W/8).
  - IDX_W = log2(DEPTH).
  - Word index = req_addr[OFF+IDX_W-1:OFF].
  - Address bits above that index are ignored, so addresses wrap modulo DEPTH words.
- FSM states:
  - CLEAR:
    - Index counter runs 0..DEPTH-1 and writes 0 to one word per cycle.
    - busy=1, req_ready=0.
    - Goes to RUN after writing word DEPTH-1.
  - RUN:
    - busy=0, req_ready=1 every cycle. There is no request backpressure in RUN.
    - Stays in RUN until reset.
- rst asserted (asynchronously):
  - State becomes CLEAR with the counter at 0.
  - Every read pipeline stage is invalidated.
  - Outputs: req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Accept = req_valid & req_ready.
- Write accept:
  - For each lane with req_be[i]=1, that byte of the word is updated at the accepting edge.
  - Lanes with req_be[i]=0 keep their contents.
  - req_be=0 is a legal no-op write.
  - Writes produce no response.
- Read accept:
  - The word is sampled at the accepting edge and enters a RD_LAT-stage valid/data shift pipeline.
  - Throughput is one read per cycle; back-to-back reads return in order, one per cycle.
- Read-after-write: a read accepted the cycle after a write to the same word returns the new data.
- rsp_rdata holds its last value when rsp_valid=0.
- Requests during CLEAR are ignored; the requester must hold req_valid until req_ready.
- Reset in the middle of CLEAR or RUN restarts CLEAR from index 0. In-flight reads are dropped and never emitted.

## Timing
- Read accepted at edge N: rsp_valid=1 in the cycle following edge N+RD_LAT-1, i.e. visible RD_LAT cycles after acceptance.
- Clear duration: after rst deasserts, exactly DEPTH rising edges complete CLEAR. req_ready and !busy are first high in the cycle after the DEPTH-th edge.
- Write effect is visible to a read accepted at edge N+1 or later.
- No combinational path from req_* to rsp_*. req_ready depends only on state.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - An accepted request with req_addr[OFF-1:0] != 0 is misaligned.
  - A misaligned write is suppressed; memory is unchanged.
  - Every misaligned request (read or write) produces one response after RD_LAT cycles with rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - Aligned responses carry rsp_err=0.
- DMEM_ALIGN_CHECK_EN undefined:
  - Low address bits are ignored; the access goes to the containing word.
  - rsp_err is tied to 0 and writes never generate responses.

## Test plan
- Reset/clear (DEPTH=16):
  - Pulse rst, then count edges → busy=1 and req_ready=0 for 16 cycles, then req_ready=1.
  - Read every word → all return 0x00000000.
- Byte enables (RD_LAT=1):
  - Write 0xCAD9C562 to addr 0x10 with be=4'hF, then write 0x11223344 with be=4'b0101.
  - Read 0x10 → rsp_rdata=0xCA22C544 exactly one cycle after accept.
- Latency/throughput (RD_LAT=3):
  - Words 0..3 hold 0xA0..0xA3; issue reads of 0x0, 0x4, 0x8, 0xC on consecutive cycles.
  - Required: rsp_valid high for 4 consecutive cycles starting 3 cycles after the first accept, data 0xA0..0xA3 in order.
- Wrap/RAW (DEPTH=1024):
  - Write 0xFDD1DACC to addr 0x1010, then read addr 0x0010 the next cycle → 0xFDD1DACC.
- Reset mid-flight (RD_LAT=4):
  - Accept a read, assert rst two cycles later → no rsp_valid is ever emitted for it, and CLEAR restarts from 0.
- Alignment (macro defined):
  - Read addr 0x6 → rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - Write 0xFFFFFFFF to addr 0x5 → error response; word 1 unchanged.
- Alignment (macro undefined): read addr 0x6 returns word 1 with rsp_err=0.
